// File: rtl/tug_of_war_top.sv
// Two-player tug-of-war on a 7-LED bar.
// Each button is synchronised, optionally debounced and edge-detected.
// A small FSM moves the lit "rope" LED, and a registered decoder drives the bar.

module tug_btn_cond #(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  input  logic flush_done,
  output logic press
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_lvl;
  logic                   filt_lvl;
  logic                   prev_q;
  logic                   armed_q;

  assign sync_lvl = sync_q[SYNC_STAGES-1];

  // Bring the asynchronous pin into the clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_no_db
      assign filt_lvl = sync_lvl;
    end else begin : g_db
      localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
      localparam logic [CW-1:0] RELOAD = CW'(DEBOUNCE_CYCLES - 1);
      logic [CW-1:0] cnt_q;
      logic          filt_q;

      // Accept a new level only after it has been stable for DEBOUNCE_CYCLES.
      // The down-counter restarts whenever the input agrees with the accepted level.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          cnt_q  <= '0;
          filt_q <= 1'b0;
        end else if (sync_lvl == filt_q) begin
          cnt_q <= RELOAD;
        end else if (cnt_q == '0) begin
          filt_q <= sync_lvl;
          cnt_q  <= RELOAD;
        end else begin
          cnt_q <= cnt_q - CW'(1);
        end
      end

      assign filt_lvl = filt_q;
    end
  endgenerate

  // Edge-detector history.
  // Arming only happens once the synchroniser holds real pin samples and the
  // pin reads low, so a button held through reset release is never counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      prev_q <= filt_lvl;
      if (flush_done && !sync_lvl) armed_q <= 1'b1;
    end
  end

  assign press = filt_lvl & ~prev_q & armed_q;

endmodule

// state | meaning
// ST_N    | rope centred
// ST_L1-3 | rope 1..3 steps toward the left player
// ST_R1-3 | rope 1..3 steps toward the right player
// ST_WINL | left player won, latched until reset
// ST_WINR | right player won, latched until reset
module tug_of_war_top #(
  parameter int DEBOUNCE_CYCLES = 0,
  parameter int SYNC_STAGES     = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pbl,
  input  logic       pbr,
  output logic [6:0] leds_out
);

  typedef enum logic [3:0] {
    ST_N, ST_L1, ST_L2, ST_L3, ST_R1, ST_R2, ST_R3, ST_WINL, ST_WINR
  } state_t;

  localparam int FW = $clog2(SYNC_STAGES + 1);

  state_t        state_q, state_d;
  logic [6:0]    leds_d;
  logic [FW-1:0] flush_q;
  logic          flush_done;
  logic          press_l, press_r;

  // Count out the synchroniser depth after reset so that arming sees real pin samples.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 flush_q <= FW'(SYNC_STAGES);
    else if (flush_q != '0)   flush_q <= flush_q - FW'(1);
  end

  assign flush_done = (flush_q == '0);

  tug_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_btn_l (
    .clk        (clk),
    .rst        (rst),
    .btn        (pbl),
    .flush_done (flush_done),
    .press      (press_l)
  );

  tug_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .SYNC_STAGES(SYNC_STAGES)) u_btn_r (
    .clk        (clk),
    .rst        (rst),
    .btn        (pbr),
    .flush_done (flush_done),
    .press      (press_r)
  );

  // State register and registered LED decode.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_N;
      leds_out <= 7'b0001000;
    end else begin
      state_q  <= state_d;
      leds_out <= leds_d;
    end
  end

  // Next-state logic: a lone press moves the rope, and simultaneous presses cancel.
  // From an extreme the loser's press jumps two steps back toward the centre.
  always_comb begin
    state_d = state_q;
    if (press_l && !press_r) begin
      unique case (state_q)
        ST_R3:   state_d = ST_R1;
        ST_R2:   state_d = ST_R1;
        ST_R1:   state_d = ST_N;
        ST_N:    state_d = ST_L1;
        ST_L1:   state_d = ST_L2;
        ST_L2:   state_d = ST_L3;
        ST_L3:   state_d = ST_WINL;
        default: state_d = state_q;
      endcase
    end else if (press_r && !press_l) begin
      unique case (state_q)
        ST_L3:   state_d = ST_L1;
        ST_L2:   state_d = ST_L1;
        ST_L1:   state_d = ST_N;
        ST_N:    state_d = ST_R1;
        ST_R1:   state_d = ST_R2;
        ST_R2:   state_d = ST_R3;
        ST_R3:   state_d = ST_WINR;
        default: state_d = state_q;
      endcase
    end
  end

  // LED pattern for the current state.
  always_comb begin
    leds_d = 7'b0001000;
    unique case (state_q)
      ST_L3:   leds_d = 7'b1000000;
      ST_L2:   leds_d = 7'b0100000;
      ST_L1:   leds_d = 7'b0010000;
      ST_N:    leds_d = 7'b0001000;
      ST_R1:   leds_d = 7'b0000100;
      ST_R2:   leds_d = 7'b0000010;
      ST_R3:   leds_d = 7'b0000001;
      ST_WINL: leds_d = 7'b1110000;
      ST_WINR: leds_d = 7'b0000111;
      default: leds_d = 7'b0001000;
    endcase
  end

endmodule

// File: tb/tb_tug_of_war_top.sv
// Self-checking bench for tug_of_war_top (default parameters).
module tb_tug_of_war_top;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pbl = 1'b0;
  logic       pbr = 1'b0;
  logic [6:0] leds_out;

  int n_checks = 0;
  int n_fail   = 0;

  typedef enum int {A_RST, A_L, A_R, A_BOTH, A_HOLD_R} action_t;
  typedef struct {
    action_t    act;
    logic [6:0] exp;
  } vec_t;

  vec_t vq[$];

  // Reference model: rope position (+ = toward left), win 0 none / 1 left / 2 right.
  int m_pos = 0;
  int m_win = 0;

  tug_of_war_top dut (
    .clk      (clk),
    .rst      (rst),
    .pbl      (pbl),
    .pbr      (pbr),
    .leds_out (leds_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: leds_out=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [6:0] model_leds();
    logic [6:0] one;
    one = 7'b0000001;
    if (m_win == 1) return 7'b1110000;
    if (m_win == 2) return 7'b0000111;
    return one << (3 + m_pos);
  endfunction

  task automatic model_press(input bit left);
    if (m_win != 0) return;
    if (left) begin
      if (m_pos == 3)       m_win = 1;
      else if (m_pos == -3) m_pos = -1;
      else                  m_pos = m_pos + 1;
    end else begin
      if (m_pos == -3)      m_win = 2;
      else if (m_pos == 3)  m_pos = 1;
      else                  m_pos = m_pos - 1;
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(negedge clk);
    check("in_reset", leds_out, 7'b0001000);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    m_pos = 0;
    m_win = 0;
  endtask

  task automatic do_press(input bit l, input bit r, input int hold);
    @(negedge clk);
    pbl = l;
    pbr = r;
    repeat (hold) @(negedge clk);
    pbl = 1'b0;
    pbr = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic do_action(input action_t a);
    case (a)
      A_RST:    do_reset(10);
      A_L:      do_press(1'b1, 1'b0, 8);
      A_R:      do_press(1'b0, 1'b1, 8);
      A_BOTH:   do_press(1'b1, 1'b1, 8);
      A_HOLD_R: do_press(1'b0, 1'b1, 50);
      default:  ;
    endcase
  endtask

  initial begin
    vq.push_back('{A_RST,    7'b0001000});
    vq.push_back('{A_R,      7'b0000100});
    vq.push_back('{A_R,      7'b0000010});
    vq.push_back('{A_R,      7'b0000001});
    vq.push_back('{A_L,      7'b0000100});
    vq.push_back('{A_L,      7'b0001000});
    vq.push_back('{A_R,      7'b0000100});
    vq.push_back('{A_R,      7'b0000010});
    vq.push_back('{A_R,      7'b0000001});
    vq.push_back('{A_R,      7'b0000111});
    vq.push_back('{A_L,      7'b0000111});
    vq.push_back('{A_R,      7'b0000111});
    vq.push_back('{A_RST,    7'b0001000});
    vq.push_back('{A_L,      7'b0010000});
    vq.push_back('{A_L,      7'b0100000});
    vq.push_back('{A_L,      7'b1000000});
    vq.push_back('{A_R,      7'b0010000});
    vq.push_back('{A_L,      7'b0100000});
    vq.push_back('{A_L,      7'b1000000});
    vq.push_back('{A_L,      7'b1110000});
    vq.push_back('{A_R,      7'b1110000});
    vq.push_back('{A_RST,    7'b0001000});
    vq.push_back('{A_R,      7'b0000100});
    vq.push_back('{A_L,      7'b0001000});
    vq.push_back('{A_L,      7'b0010000});
    vq.push_back('{A_BOTH,   7'b0010000});
    vq.push_back('{A_RST,    7'b0001000});
    vq.push_back('{A_HOLD_R, 7'b0000100});
    vq.push_back('{A_BOTH,   7'b0000100});

    // Long reset at start: leds must show the centre during and after.
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_start", leds_out, 7'b0001000);
    do_reset(100);
    check("after_reset", leds_out, 7'b0001000);

    // Directed vector table.
    foreach (vq[i]) begin
      do_action(vq[i].act);
      check($sformatf("vec%0d", i), leds_out, vq[i].exp);
    end

    // Latency from pin to leds: unchanged after 3 edges, updated after the 4th.
    do_reset(4);
    @(negedge clk);
    pbr = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("latency_3", leds_out, 7'b0001000);
    @(posedge clk);
    #1 check("latency_4", leds_out, 7'b0000100);
    @(negedge clk);
    pbr = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset mid-cycle while at R2.
    do_press(1'b0, 1'b1, 8);
    check("pre_async_r2", leds_out, 7'b0000010);
    @(posedge clk);
    #3 rst = 1'b0;
    #1 check("async_reset", leds_out, 7'b0001000);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Button held through reset release must not register.
    @(negedge clk);
    pbr = 1'b1;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    check("held_thru_reset", leds_out, 7'b0001000);
    pbr = 1'b0;
    repeat (4) @(negedge clk);
    do_press(1'b0, 1'b1, 8);
    check("rearm_after_hold", leds_out, 7'b0000100);

    // Randomised play against the reference model.
    do_reset(5);
    for (int k = 0; k < 150; k++) begin
      int sel;
      sel = $urandom_range(0, 19);
      if (sel == 0) begin
        do_reset(3);
      end else if (sel <= 9) begin
        do_press(1'b1, 1'b0, $urandom_range(3, 12));
        model_press(1'b1);
      end else if (sel <= 18) begin
        do_press(1'b0, 1'b1, $urandom_range(3, 12));
        model_press(1'b0);
      end else begin
        do_press(1'b1, 1'b1, $urandom_range(3, 12));
      end
      check($sformatf("rand%0d", k), leds_out, model_leds());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
